mod_counter: RTL and testbench

Parametrised up/down modulo counter, the next generation of the team's free-running enable counter. Adds configurable width and terminal value, direction control, wrap or saturate mode, synchronous clear and parallel load, a registered terminal-count pulse and a sticky wrap flag. It is the common building block for pixel/line scan counters, frame counters and timeout timers in the GPU pipeline.

---
 rtl/mod_counter.sv | 116 +++++++++++
 tb/tb_mod_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate, clear, load, tc pulse and sticky wrap flag.
// Optional enable prescaler is built only when MOD_COUNTER_PRESCALE_EN is defined.
module mod_counter #(
   parameter int WIDTH     = 8,
   parameter int MAX_VAL   = 2**WIDTH - 1,
   parameter int RESET_VAL = 0,
   parameter int PRESCALE  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic             saturate,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

   if ((MAX_VAL < 1) || (longint'(MAX_VAL) >= (longint'(1) << WIDTH)) ||
       (RESET_VAL < 0) || (RESET_VAL > MAX_VAL) || (PRESCALE < 1)) begin : g_param_check
      $error("mod_counter: illegal parameters WIDTH=%0d MAX_VAL=%0d RESET_VAL=%0d PRESCALE=%0d",
             WIDTH, MAX_VAL, RESET_VAL, PRESCALE);
   end

   logic             tick;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             wrapped_q, wrapped_d;

`ifdef MOD_COUNTER_PRESCALE_EN
   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q, pre_d;

   always_comb begin
      pre_d = pre_q;
      tick  = 1'b0;
      if (clear || load) begin
         pre_d = '0;
      end else if (enable) begin
         if (pre_q == PRE_LAST) begin
            tick  = 1'b1;
            pre_d = '0;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pre_q <= '0;
      else      pre_q <= pre_d;
   end
`else
   assign tick = enable;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      count_d   = count_q;
      tc_d      = 1'b0;
      wrapped_d = wrapped_q;
      if (clear) begin
         count_d   = RESET_C;
         wrapped_d = 1'b0;
      end else if (load) begin
         count_d = (load_val > MAX_C) ? MAX_C : load_val;
      end else if (tick) begin
         if (dir) begin
            if (count_q < MAX_C) begin
               count_d = count_q + ONE_C;
               tc_d    = saturate && (count_d == MAX_C);
            end else if (!saturate) begin
               count_d   = '0;
               tc_d      = 1'b1;
               wrapped_d = 1'b1;
            end
         end else begin
            if (count_q != '0) begin
               count_d = count_q - ONE_C;
               tc_d    = saturate && (count_d == '0);
            end else if (!saturate) begin
               count_d   = MAX_C;
               tc_d      = 1'b1;
               wrapped_d = 1'b1;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= RESET_C;
         tc_q      <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         tc_q      <= tc_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign wrapped = wrapped_q;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: two instances (MAX_VAL 9 and 99) share stimulus and are
// compared every cycle against a behavioural model, plus directed sequences with literal values.
module tb_mod_counter;

   localparam int RV = 5;
`ifdef MOD_COUNTER_PRESCALE_EN
   localparam int PSC_B = 3;
`else
   localparam int PSC_B = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b1, saturate = 1'b0;
   logic [7:0] load_val = '0;
   logic [7:0] count_a, count_b;
   logic       tc_a, tc_b, wrapped_a, wrapped_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(8), .MAX_VAL(9), .RESET_VAL(RV), .PRESCALE(1)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load), .load_val(load_val),
      .dir(dir), .saturate(saturate), .count(count_a), .tc(tc_a), .wrapped(wrapped_a)
   );

   mod_counter #(.WIDTH(8), .MAX_VAL(99), .RESET_VAL(RV), .PRESCALE(3)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load), .load_val(load_val),
      .dir(dir), .saturate(saturate), .count(count_b), .tc(tc_b), .wrapped(wrapped_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   typedef struct {
      int cnt;
      int pre;
      bit tc;
      bit wr;
   } model_t;

   model_t   m[2];
   const int m_max[2] = '{9, 99};
   const int m_psc[2] = '{1, PSC_B};

   // Every psc-th enabled cycle is a step; a step moves the count one place in the range 0..maxv.
   function automatic model_t model_next(model_t s, int maxv, int psc, bit en, bit clr, bit ld,
                                         int lv, bit up, bit sat);
      model_t n = s;
      n.tc = 1'b0;
      if (clr) begin
         n.cnt = RV;
         n.wr  = 1'b0;
         n.pre = 0;
      end else if (ld) begin
         n.cnt = (lv > maxv) ? maxv : lv;
         n.pre = 0;
      end else if (en) begin
         n.pre = (s.pre + 1) % psc;
         if (n.pre == 0) begin
            if (up) begin
               if (s.cnt != maxv) begin
                  n.cnt = s.cnt + 1;
                  n.tc  = sat && (n.cnt == maxv);
               end else if (!sat) begin
                  n.cnt = 0;
                  n.tc  = 1'b1;
                  n.wr  = 1'b1;
               end
            end else begin
               if (s.cnt != 0) begin
                  n.cnt = s.cnt - 1;
                  n.tc  = sat && (n.cnt == 0);
               end else if (!sat) begin
                  n.cnt = maxv;
                  n.tc  = 1'b1;
                  n.wr  = 1'b1;
               end
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) m[i] <= '{cnt: RV, pre: 0, tc: 1'b0, wr: 1'b0};
         else      m[i] <= model_next(m[i], m_max[i], m_psc[i], enable, clear, load,
                                      int'(load_val), dir, saturate);
      end
   end

   always @(negedge clk) begin
      check("a.count",   count_a,   m[0].cnt);
      check("a.tc",      tc_a,      m[0].tc);
      check("a.wrapped", wrapped_a, m[0].wr);
      check("b.count",   count_b,   m[1].cnt);
      check("b.tc",      tc_b,      m[1].tc);
      check("b.wrapped", wrapped_b, m[1].wr);
   end

   // Drive one cycle of inputs at the falling edge, then return just after the rising edge.
   task automatic apply(input bit en, input bit clr, input bit ld, input int lv,
                        input bit up, input bit sat);
      @(negedge clk);
      enable   = en;
      clear    = clr;
      load     = ld;
      load_val = 8'(lv);
      dir      = up;
      saturate = sat;
      @(posedge clk);
      #1;
   endtask

   int en_pat[11]  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
`ifdef MOD_COUNTER_PRESCALE_EN
   int exp_pre[11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
`else
   int exp_pre[11] = '{1, 2, 3, 4, 4, 4, 5, 6, 7, 8, 9};
`endif
   int exp_dn[6]   = '{2, 1, 0, 0, 0, 0};

   initial begin
      rst = 1'b0;

      // Reset held for three cycles, then released with enable low.
      repeat (3) begin
         apply(0, 0, 0, 0, 1, 0);
         check("rst.count", count_a, RV);
         check("rst.tc", tc_a, 0);
         check("rst.wrapped", wrapped_a, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rel.count_a", count_a, RV);
      check("rel.count_b", count_b, RV);
      repeat (2) begin
         apply(0, 0, 0, 0, 1, 0);
         check("idle.count", count_a, RV);
         check("idle.tc", tc_a, 0);
      end

      // Up wrap from 0 with MAX_VAL=9.
      apply(0, 0, 1, 0, 1, 0);
      check("upw.load0", count_a, 0);
      for (int i = 1; i <= 12; i++) begin
         apply(1, 0, 0, 0, 1, 0);
         check("upw.count", count_a, i % 10);
         check("upw.tc", tc_a, (i == 10) ? 1 : 0);
         check("upw.wrapped", wrapped_a, (i >= 10) ? 1 : 0);
      end

      // Clear drops the sticky flag; then down-saturate from 3.
      apply(0, 1, 0, 0, 0, 1);
      check("clr.count", count_a, RV);
      check("clr.wrapped", wrapped_a, 0);
      apply(0, 0, 1, 3, 0, 1);
      check("dns.load3", count_a, 3);
      for (int i = 0; i < 6; i++) begin
         apply(1, 0, 0, 0, 0, 1);
         check("dns.count", count_a, exp_dn[i]);
         check("dns.tc", tc_a, (i == 2) ? 1 : 0);
         check("dns.wrapped", wrapped_a, 0);
      end

      // Priority and clamping.
      apply(0, 1, 1, 200, 1, 0);
      check("pri.clr_b", count_b, RV);
      check("pri.clr_a", count_a, RV);
      apply(0, 0, 1, 200, 1, 0);
      check("pri.clamp_b", count_b, 99);
      check("pri.clamp_a", count_a, 9);
      apply(1, 0, 1, 20, 1, 0);
      check("pri.nostep_b", count_b, 20);
      check("pri.nostep_a", count_a, 9);
      check("pri.notc_a", tc_a, 0);

      // Asynchronous reset in the middle of an up-wrap run.
      apply(0, 0, 1, 7, 1, 0);
      check("mrst.at7", count_a, 7);
      @(negedge clk);
      #1;
      enable = 1'b1;
      load   = 1'b0;
      rst    = 1'b0;
      #1;
      check("mrst.count", count_a, RV);
      check("mrst.tc", tc_a, 0);
      check("mrst.count_b", count_b, RV);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mrst.resume", count_a, RV + 1);
      apply(1, 0, 0, 0, 1, 0);
      check("mrst.resume2", count_a, RV + 2);

      // Prescaled enable on instance b.
      apply(0, 0, 1, 0, 1, 0);
      check("psc.load0", count_b, 0);
      for (int i = 0; i < 11; i++) begin
         apply(en_pat[i] != 0, 0, 0, 0, 1, 0);
         check("psc.count_b", count_b, exp_pre[i]);
      end

      // Randomised stimulus against the model.
      for (int i = 0; i < 4000; i++) begin
         bit up  = dir;
         bit sat = saturate;
         if ($urandom_range(31) == 0) up  = ~up;
         if ($urandom_range(47) == 0) sat = ~sat;
         apply($urandom_range(3) != 0, $urandom_range(63) == 0, $urandom_range(31) == 0,
               int'($urandom_range(255)), up, sat);
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
